tri_scom_req_issue: RTL

SCOM request initiator for the trilib SCOM fabric. Accepts one register access at a time from a host-side requester, launches it onto the satellite request bus (satellite ID, decoded-side address, read/not-write, write data), waits for the satellite's acknowledge with a bounded timeout, and returns read data plus a status word to the host. It is the master-side counterpart of the satellite address decoder. It produces the `sc_req`/`sc_addr`/`sc_r_nw` signals the decoder consumes and collects the `scaddr_nvld`/`sc_rd_nvld`/`sc_wr_nvld` verdicts the satellite reports back.

---
 rtl/tri_scom_req_issue.sv | 78 +++++++
 1 files changed

// File: rtl/tri_scom_req_issue.sv
// tri_scom_req_issue: one-at-a-time SCOM request initiator with ack timeout
module tri_scom_req_issue #(
  parameter int SATID_NOBITS   = 5,
  parameter int DATA_SIZE      = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      host_req_val,
  output logic                      host_req_rdy,
  input  logic [SATID_NOBITS-1:0]   host_satid,
  input  logic [10-SATID_NOBITS:0]  host_addr,
  input  logic                      host_r_nw,
  input  logic [DATA_SIZE-1:0]      host_wdata,
  output logic                      sc_req,
  output logic [SATID_NOBITS-1:0]   sc_satid,
  output logic [10-SATID_NOBITS:0]  sc_addr,
  output logic                      sc_r_nw,
  output logic [DATA_SIZE-1:0]      sc_wdata,
  input  logic                      sc_ack,
  input  logic                      sc_ack_addr_nvld,
  input  logic                      sc_ack_acc_nvld,
  input  logic [DATA_SIZE-1:0]      sc_rdata,
  output logic                      rsp_val,
  output logic [DATA_SIZE-1:0]      rsp_rdata,
  output logic [2:0]                rsp_status,
  output logic                      stray_ack
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic data_ok, busy, term;
  assign host_req_rdy = state == IDLE;
  assign busy = state == REQ || state == WAIT;
  assign term = state == WAIT && cnt == CW'(TIMEOUT_CYCLES - 1);
  // read data only passes through on a clean read ack
  assign data_ok = sc_r_nw & ~sc_ack_addr_nvld & ~sc_ack_acc_nvld;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sc_req     <= 1'b0;
      sc_satid   <= '0;
      sc_addr    <= '0;
      sc_r_nw    <= 1'b0;
      sc_wdata   <= '0;
      rsp_val    <= 1'b0;
      rsp_rdata  <= '0;
      rsp_status <= '0;
      stray_ack  <= 1'b0;
    end else begin
      sc_req  <= 1'b0;
      rsp_val <= 1'b0;
      if (sc_ack && !busy) stray_ack <= 1'b1;
      if (busy) cnt <= state == REQ ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (host_req_val) begin
          sc_satid <= host_satid;
          sc_addr  <= host_addr;
          sc_r_nw  <= host_r_nw;
          sc_wdata <= host_wdata;
          sc_req   <= 1'b1;
          state    <= REQ;
        end
        REQ, WAIT: begin
          if (sc_ack || term) begin
            state      <= RSP;
            rsp_val    <= 1'b1;
            rsp_rdata  <= sc_ack && data_ok ? sc_rdata : '0;
            rsp_status <= sc_ack ? {1'b0, sc_ack_acc_nvld & ~sc_ack_addr_nvld, sc_ack_addr_nvld} : 3'b100;
          end else state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
